// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes, state type and rotate helper for rr_arbiter8
package rr_arbiter8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] rot_mask(input logic [N_REQ-1:0] v, input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] d;
    d = {v, v} >> sh;
    return d[N_REQ-1:0];
  endfunction
endpackage

// File: rtl/prio_enc8to3.sv
// prio_enc8to3: index of the lowest set bit of an 8-bit vector, plus valid
module prio_enc8to3
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) idx = vec[i] ? IDX_W'(i) : idx;
  end
  assign valid = |vec;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold limit
// ARB_GRANT_CNT_EN adds a saturating grant_cnt output.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);
  localparam int HW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;
  if (CNT_W < 1 || HOLD_MAX < 0) begin : g_bad_param
    $error("rr_arbiter8: invalid parameters");
  end
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold;
  logic             held, forced, rel, load, enc_v;
  logic [IDX_W-1:0] arb_ptr, enc_idx, win;
  logic [N_REQ-1:0] arb_vec;
  assign held    = req[gnt_idx];
  assign forced  = (HOLD_MAX != 0) && (hold == HW'(HOLD_MAX)) && held;
  assign rel     = (state == GRANT) && (!held || forced);
  assign arb_ptr = rel ? gnt_idx + IDX_W'(1) : ptr;
  // a naturally released holder is masked; a forced one competes last
  assign arb_vec = (state == GRANT && !held) ? req & ~gnt_onehot : req;
  assign win     = enc_idx + arb_ptr;
  assign load    = (state == IDLE || rel) && enc_v;
  prio_enc8to3 u_enc (.vec(rot_mask(arb_vec, arb_ptr)), .idx(enc_idx), .valid(enc_v));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
      hold       <= '0;
    end else begin
      if (rel) ptr <= arb_ptr;
      if (load) begin
        state      <= GRANT;
        gnt_valid  <= 1'b1;
        gnt_idx    <= win;
        gnt_onehot <= N_REQ'(1) << win;
        hold       <= HW'(1);
      end else if (state == IDLE || rel) begin
        state      <= IDLE;
        gnt_valid  <= 1'b0;
        gnt_idx    <= '0;
        gnt_onehot <= '0;
        hold       <= '0;
      end else if (HOLD_MAX != 0 && hold != HW'(HOLD_MAX)) begin
        hold <= hold + HW'(1);
      end
    end
  end
`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) grant_cnt <= '0;
    else if (load && !(&grant_cnt)) grant_cnt <= grant_cnt + CNT_W'(1);
  end
`endif
endmodule
